// File: rtl/ball_motion_pkg.sv
// -----------------------------------------------------------------------------
// ball_motion_pkg
// Shared playfield geometry used by the ball motion block and the renderer
// (all positions in block units, one block = GEO_BLOCK_PX pixels), plus the
// ball FSM state type and the divider counter width.
// -----------------------------------------------------------------------------
package ball_motion_pkg;

  // Playfield geometry
  localparam int GEO_BLOCK_PX     = 10;
  localparam int GEO_CEILING_Y    = 7;
  localparam int GEO_LEFT_WALL_X  = 0;
  localparam int GEO_RIGHT_WALL_X = 79;
  localparam int GEO_PADDLE_Y     = 57;
  localparam int GEO_FLOOR_Y      = 59;
  localparam int GEO_PADDLE_W     = 8;

  // Width of the frame dividers (step counter and lost-frame counter)
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    SERVE  = 2'd0,
    MOVING = 2'd1,
    LOST   = 2'd2
  } ballState_t;

endpackage

// File: rtl/ball_motion_generic_counter.sv
// -----------------------------------------------------------------------------
// GenericCounter
// Wrapping up-counter: counts 0..MAX_COUNT on ENABLE, then wraps to 0.
// Ports:
//   CLK    - clock
//   RESET  - synchronous active-high reset (count -> 0)
//   CLEAR  - synchronous clear (count -> 0), overrides ENABLE
//   ENABLE - advance the count this cycle
//   COUNT  - current count
// -----------------------------------------------------------------------------
module GenericCounter #(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CLEAR,
  input  logic             ENABLE,
  output logic [WIDTH-1:0] COUNT
);

  always_ff @(posedge CLK) begin
    if (RESET || CLEAR) begin
      COUNT <= '0;
    end else if (ENABLE) begin
      if (COUNT == WIDTH'(MAX_COUNT)) begin
        COUNT <= '0;
      end else begin
        COUNT <= COUNT + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// -----------------------------------------------------------------------------
// ball_motion
// Ball position/direction FSM (SERVE, MOVING, LOST) advanced once per frame.
// Ports:
//   CLK         - pixel clock
//   RESET       - synchronous active-high reset
//   FRAME_START - one-cycle pulse at frame start
//   PADDLE_X    - paddle leftmost block column
//   LAUNCH      - serve request, accepted in any cycle
//   BALL_X      - ball block column (registered)
//   BALL_Y      - ball block row (registered)
//   BALL_VALID  - ball is drawn (registered)
//   BALL_LOST   - one-cycle pulse when the ball is missed (registered)
// -----------------------------------------------------------------------------
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int CEILING_Y       = GEO_CEILING_Y,
  parameter int LEFT_WALL_X     = GEO_LEFT_WALL_X,
  parameter int RIGHT_WALL_X    = GEO_RIGHT_WALL_X,
  parameter int PADDLE_Y        = GEO_PADDLE_Y,
  parameter int FLOOR_Y         = GEO_FLOOR_Y,
  parameter int PADDLE_W        = GEO_PADDLE_W,
  parameter int FRAMES_PER_STEP = 4,
  parameter int LOST_FRAMES     = 60
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FRAME_START,
  input  logic [6:0] PADDLE_X,
  input  logic       LAUNCH,
  output logic [6:0] BALL_X,
  output logic [5:0] BALL_Y,
  output logic       BALL_VALID,
  output logic       BALL_LOST
);

  // The launch frame counts as the first frame of the first step period, so
  // a step fires on the frame where the counter moves onto its last value.
  localparam int STEP_FIRE = (FRAMES_PER_STEP > 1) ? FRAMES_PER_STEP - 2 : 0;

  ballState_t stateReg, stateNext;
  logic [6:0] ballXReg, ballXNext;
  logic [5:0] ballYReg, ballYNext;
  logic       dxNegReg, dxNegNext;   // 1: moving left
  logic       dyNegReg, dyNegNext;   // 1: moving up
  logic       validReg, validNext;
  logic       lostReg, lostNext;
  logic       pendingReg, pendingNext;

  logic [CNT_W-1:0] stepCount, lostCount;
  logic             stepClear, lostClear;
  logic             stepDue, lostDone;

  // 8-bit intermediates
  logic [7:0] x8, y8, xPlus, xMinus, yPlus, yMinus;
  logic [7:0] serveX8, padLeft8, padRight8;
  logic [6:0] serveX;
  logic       onPaddle;

  assign x8        = {1'b0, ballXReg};
  assign y8        = {2'b00, ballYReg};
  assign xPlus     = x8 + 8'd1;
  assign xMinus    = x8 - 8'd1;
  assign yPlus     = y8 + 8'd1;
  assign yMinus    = y8 - 8'd1;
  assign padLeft8  = {1'b0, PADDLE_X};
  assign padRight8 = padLeft8 + 8'(PADDLE_W - 1);
  assign onPaddle  = (x8 >= padLeft8) && (x8 <= padRight8);
  assign serveX8   = padLeft8 + 8'(PADDLE_W / 2);
  assign serveX    = (serveX8 > 8'(RIGHT_WALL_X - 1)) ? 7'(RIGHT_WALL_X - 1) : serveX8[6:0];

  assign stepDue  = (FRAMES_PER_STEP <= 1) || (stepCount == CNT_W'(STEP_FIRE));
  assign lostDone = (lostCount == CNT_W'(LOST_FRAMES - 1));

  GenericCounter #(.WIDTH(CNT_W), .MAX_COUNT(FRAMES_PER_STEP - 1)) stepCounter (
    .CLK    (CLK),
    .RESET  (RESET),
    .CLEAR  (stepClear),
    .ENABLE (FRAME_START && (stateReg == MOVING)),
    .COUNT  (stepCount)
  );

  GenericCounter #(.WIDTH(CNT_W), .MAX_COUNT(LOST_FRAMES - 1)) lostCounter (
    .CLK    (CLK),
    .RESET  (RESET),
    .CLEAR  (lostClear),
    .ENABLE (FRAME_START && (stateReg == LOST)),
    .COUNT  (lostCount)
  );

  always_comb begin
    stateNext   = stateReg;
    ballXNext   = ballXReg;
    ballYNext   = ballYReg;
    dxNegNext   = dxNegReg;
    dyNegNext   = dyNegReg;
    validNext   = validReg;
    lostNext    = 1'b0;
    pendingNext = pendingReg | LAUNCH;
    stepClear   = 1'b0;
    lostClear   = 1'b0;

    if (FRAME_START) begin
      // The latch is consumed or discarded at every frame start.
      pendingNext = 1'b0;
      case (stateReg)
        SERVE: begin
          ballXNext = serveX;
          ballYNext = 6'(PADDLE_Y - 1);
          validNext = 1'b1;
          if (pendingReg || LAUNCH) begin
            stateNext = MOVING;
            dxNegNext = 1'b0;
            dyNegNext = 1'b1;
            stepClear = 1'b1;
          end
        end

        MOVING: begin
          if (stepDue) begin
            // X axis: reflect off a wall by holding position for one step
            if (!dxNegReg && xPlus == 8'(RIGHT_WALL_X)) begin
              dxNegNext = 1'b1;
            end else if (dxNegReg && xMinus == 8'(LEFT_WALL_X)) begin
              dxNegNext = 1'b0;
            end else begin
              ballXNext = dxNegReg ? xMinus[6:0] : xPlus[6:0];
            end

            // Y axis, evaluated from the same pre-step values
            if (dyNegReg && yMinus == 8'(CEILING_Y)) begin
              dyNegNext = 1'b0;
            end else if (!dyNegReg && yPlus == 8'(PADDLE_Y) && onPaddle) begin
              dyNegNext = 1'b1;
            end else if (!dyNegReg && y8 == 8'(FLOOR_Y)) begin
              // Miss: freeze the ball where it is and hide it
              stateNext = LOST;
              ballXNext = ballXReg;
              validNext = 1'b0;
              lostNext  = 1'b1;
              lostClear = 1'b1;
            end else begin
              ballYNext = dyNegReg ? yMinus[5:0] : yPlus[5:0];
            end
          end
        end

        LOST: begin
          if (lostDone) begin
            stateNext = SERVE;
            ballXNext = serveX;
            ballYNext = 6'(PADDLE_Y - 1);
            validNext = 1'b1;
          end
        end

        default: begin
          stateNext = SERVE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stateReg   <= SERVE;
      ballXReg   <= 7'(LEFT_WALL_X + 1);
      ballYReg   <= 6'(PADDLE_Y - 1);
      dxNegReg   <= 1'b0;
      dyNegReg   <= 1'b1;
      validReg   <= 1'b1;
      lostReg    <= 1'b0;
      pendingReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      ballXReg   <= ballXNext;
      ballYReg   <= ballYNext;
      dxNegReg   <= dxNegNext;
      dyNegReg   <= dyNegNext;
      validReg   <= validNext;
      lostReg    <= lostNext;
      pendingReg <= pendingNext;
    end
  end

  assign BALL_X     = ballXReg;
  assign BALL_Y     = ballYReg;
  assign BALL_VALID = validReg;
  assign BALL_LOST  = lostReg;

endmodule

// File: tb/tb_ball_motion.sv
// -----------------------------------------------------------------------------
// tb_ball_motion
// Directed bench for ball_motion: serve-position table, a full flight with
// checkpoint table (wall, ceiling, paddle hit), a miss into LOST and back,
// a corner hit, and reset coincident with FRAME_START/LAUNCH.
// -----------------------------------------------------------------------------
module tb_ball_motion;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FRAME_START;
  logic [6:0] PADDLE_X;
  logic       LAUNCH;
  logic [6:0] BALL_X;
  logic [5:0] BALL_Y;
  logic       BALL_VALID;
  logic       BALL_LOST;

  int total = 0;
  int bad   = 0;
  int framesDone;

  ball_motion dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FRAME_START (FRAME_START),
    .PADDLE_X    (PADDLE_X),
    .LAUNCH      (LAUNCH),
    .BALL_X      (BALL_X),
    .BALL_Y      (BALL_Y),
    .BALL_VALID  (BALL_VALID),
    .BALL_LOST   (BALL_LOST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [6:0] paddleX;
    int         expX;
    int         expY;
  } serveVec_t;

  typedef struct {
    int step;
    int expX;
    int expY;
    bit launchBefore;
  } flightVec_t;

  serveVec_t  serveTab[7];
  flightVec_t flightTab[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic checkPos(input string name, input int x, input int y);
    check({name, ".x"}, 32'(BALL_X), 32'(x));
    check({name, ".y"}, 32'(BALL_Y), 32'(y));
  endtask

  // Drive/sample on the falling edge; each frame is a pulse plus an idle cycle.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      FRAME_START = 1'b1;
      @(negedge CLK);
      FRAME_START = 1'b0;
      @(negedge CLK);
    end
  endtask

  task automatic pulseLaunch();
    LAUNCH = 1'b1;
    @(negedge CLK);
    LAUNCH = 1'b0;
  endtask

  task automatic doReset();
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Advance to the end of ball step k (step k lands on frame 4k after launch frame 1)
  task automatic toStep(input int k);
    frames(4 * k - framesDone);
    framesDone = 4 * k;
  endtask

  initial begin
    serveTab[0] = '{7'd36,  40, 56};
    serveTab[1] = '{7'd0,    4, 56};
    serveTab[2] = '{7'd70,  74, 56};
    serveTab[3] = '{7'd74,  78, 56};
    serveTab[4] = '{7'd75,  78, 56};
    serveTab[5] = '{7'd127, 78, 56};
    serveTab[6] = '{7'd36,  40, 56};

    flightTab[0] = '{38, 78, 18, 1'b0};
    flightTab[1] = '{39, 78, 17, 1'b0};
    flightTab[2] = '{40, 77, 16, 1'b1};
    flightTab[3] = '{48, 69,  8, 1'b0};
    flightTab[4] = '{49, 68,  8, 1'b0};
    flightTab[5] = '{50, 67,  9, 1'b0};
    flightTab[6] = '{97, 20, 56, 1'b0};

    RESET = 1'b1; FRAME_START = 1'b0; LAUNCH = 1'b0; PADDLE_X = 7'd36;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    // Reset state
    checkPos("reset", 1, 56);
    check("reset.valid", 32'(BALL_VALID), 32'd1);
    check("reset.lost", 32'(BALL_LOST), 32'd0);

    // Serve position table
    for (int i = 0; i < 7; i++) begin
      PADDLE_X = serveTab[i].paddleX;
      frames(1);
      checkPos($sformatf("serve[%0d]", i), serveTab[i].expX, serveTab[i].expY);
      check($sformatf("serve[%0d].valid", i), 32'(BALL_VALID), 32'd1);
    end

    // Launch latency: nothing moves until the 4th frame
    pulseLaunch();
    frames(1); checkPos("launch.f1", 40, 56);
    frames(1); checkPos("launch.f2", 40, 56);
    frames(1); checkPos("launch.f3", 40, 56);
    frames(1); checkPos("launch.f4", 41, 55);
    framesDone = 4;

    // Flight checkpoints (LAUNCH while moving must not disturb the ball)
    for (int i = 0; i < 7; i++) begin
      if (flightTab[i].launchBefore) pulseLaunch();
      toStep(flightTab[i].step);
      checkPos($sformatf("flight.s%0d", flightTab[i].step), flightTab[i].expX, flightTab[i].expY);
    end

    // Paddle hit at the right edge of the paddle
    PADDLE_X = 7'd13;
    toStep(98); checkPos("hit.s98", 19, 56);
    toStep(99); checkPos("hit.s99", 18, 55);
    check("hit.valid", 32'(BALL_VALID), 32'd1);

    // Miss path: same flight, paddle one column to the right of the ball
    doReset();
    PADDLE_X = 7'd36;
    frames(1);
    checkPos("miss.serve", 40, 56);
    pulseLaunch();
    frames(1);
    framesDone = 1;
    toStep(97);  checkPos("miss.s97", 20, 56);
    PADDLE_X = 7'd21;
    toStep(98);  checkPos("miss.s98", 19, 57);
    toStep(99);  checkPos("miss.s99", 18, 58);
    toStep(100); checkPos("miss.s100", 17, 59);
    frames(3);
    FRAME_START = 1'b1;
    @(negedge CLK);
    FRAME_START = 1'b0;
    check("miss.lostPulse", 32'(BALL_LOST), 32'd1);
    check("miss.validOff", 32'(BALL_VALID), 32'd0);
    @(negedge CLK);
    check("miss.lostPulseEnd", 32'(BALL_LOST), 32'd0);

    // LAUNCH while lost is discarded at the next frame start
    pulseLaunch();
    for (int f = 1; f < 60; f++) begin
      frames(1);
      check($sformatf("lost.f%0d.valid", f), 32'(BALL_VALID), 32'd0);
    end
    frames(1);
    check("lost.f60.valid", 32'(BALL_VALID), 32'd1);
    checkPos("lost.f60", 25, 56);
    frames(8);
    checkPos("lost.noRelaunch", 25, 56);

    // Corner hit: ceiling and right wall on the same step
    doReset();
    PADDLE_X = 7'd26;
    frames(1);
    checkPos("corner.serve", 30, 56);
    pulseLaunch();
    frames(1);
    framesDone = 1;
    toStep(48); checkPos("corner.s48", 78, 8);
    toStep(49); checkPos("corner.s49", 78, 8);
    toStep(50); checkPos("corner.s50", 77, 9);

    // Reset wins over a coincident FRAME_START and LAUNCH
    RESET = 1'b1; FRAME_START = 1'b1; LAUNCH = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; FRAME_START = 1'b0; LAUNCH = 1'b0;
    checkPos("rstFs", 1, 56);
    check("rstFs.valid", 32'(BALL_VALID), 32'd1);
    check("rstFs.lost", 32'(BALL_LOST), 32'd0);
    PADDLE_X = 7'd36;
    frames(5);
    checkPos("rstFs.noLaunch", 40, 56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CEILING_Y, 7, ceiling block row.
- LEFT_WALL_X, 0, left wall block column.
- RIGHT_WALL_X, 79, right wall block column.
- PADDLE_Y, 57, paddle block row.
- FLOOR_Y, 59, last playable block row.
- PADDLE_W, 8, paddle width in blocks.
- FRAMES_PER_STEP, 4, frames per ball step.
- LOST_FRAMES, 60, frames the ball stays invisible after a loss.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, pixel clock.
- RESET, in, 1, synchronous active-high reset.
- FRAME_START, in, 1, one-cycle pulse at frame start from the video timing stage.
- PADDLE_X, in, 7, paddle leftmost block column.
- LAUNCH, in, 1, serve request, any cycle.
- BALL_X, out, 7, ball block column.
- BALL_Y, out, 6, ball block row.
- BALL_VALID, out, 1, ball is drawn.
- BALL_LOST, out, 1, one-cycle pulse on a miss.
REQ-003 Clocking SHALL be: one clock; reset is synchronous and active-high, ports named CLK and RESET.
REQ-004 All outputs SHALL be registered and feed the renderer directly, in block units.

Function
REQ-005 The FSM SHALL have exactly three states: SERVE, MOVING and LOST.
REQ-006 State, position and direction SHALL change only in the cycle after FRAME_START is high (1-cycle latency), with two exceptions: the LAUNCH latch and RESET.
REQ-007 In SERVE, each FRAME_START SHALL set BALL_X to min(PADDLE_X + PADDLE_W/2, RIGHT_WALL_X-1) and BALL_Y to PADDLE_Y-1, and SHALL drive BALL_VALID=1.
REQ-008 LAUNCH SHALL set a pending latch in any cycle; the latch SHALL be consumed at the next FRAME_START in SERVE and ignored and cleared in other states.
REQ-009 SERVE with the latch set at FRAME_START SHALL enter MOVING with dx=+1, dy=-1 and the step counter cleared.
REQ-010 In MOVING, a step SHALL occur on every FRAMES_PER_STEP-th FRAME_START; the counter SHALL wrap from FRAMES_PER_STEP-1 to 0.
REQ-011 X axis per step:
- if dx=+1 and BALL_X+1==RIGHT_WALL_X, dx becomes -1 and BALL_X holds;
- if dx=-1 and BALL_X-1==LEFT_WALL_X, dx becomes +1 and BALL_X holds;
- otherwise BALL_X becomes BALL_X+dx.
REQ-012 Y axis per step:
- if dy=-1 and BALL_Y-1==CEILING_Y, dy becomes +1 and BALL_Y holds;
- if dy=+1 and BALL_Y+1==PADDLE_Y and PADDLE_X <= BALL_X <= PADDLE_X+PADDLE_W-1 (8-bit compare, no wrap), dy becomes -1 and BALL_Y holds;
- if dy=+1 and BALL_Y==FLOOR_Y, the FSM goes to LOST;
- otherwise BALL_Y becomes BALL_Y+dy.
REQ-013 Both axes SHALL be evaluated from pre-step values in the same step; a corner hit SHALL reflect both axes.
REQ-014 Entering LOST SHALL pulse BALL_LOST for exactly one cycle, drive BALL_VALID=0 and clear the frame counter.
REQ-015 LOST SHALL return to SERVE after LOST_FRAMES FRAME_STARTs.
REQ-016 Arithmetic SHALL use 8-bit intermediates; BALL_X and BALL_Y SHALL never leave the range bounded by the walls, CEILING_Y and FLOOR_Y.

Reset
REQ-017 RESET SHALL force state SERVE, BALL_X=LEFT_WALL_X+1, BALL_Y=PADDLE_Y-1, BALL_VALID=1, BALL_LOST=0, dx=+1, dy=-1, counters 0 and latch cleared.
REQ-018 RESET SHALL take priority over FRAME_START and LAUNCH in the same cycle and SHALL abort any state mid-operation.

Structure
REQ-019 Playfield constants (CEILING_Y, wall columns, PADDLE_Y, FLOOR_Y, block size 10 px) SHALL live in a shared game_geometry include used by both this block and the renderer.
REQ-020 The step and lost-frame dividers SHALL reuse the existing GenericCounter, enabled by FRAME_START; no other sub-module.

Verification
REQ-021 Reset then PADDLE_X=36 and one FRAME_START -> BALL_X=40, BALL_Y=56, BALL_VALID=1.
REQ-022 LAUNCH pulse then 4 FRAME_STARTs from (40,56) -> (41,55) one cycle after the 4th; no earlier change.
REQ-023 Ball at (78,8) with dx=+1, dy=-1 at a step -> position holds, dx=-1 and dy=+1 (corner).
REQ-024 Ball at (20,56) with dy=+1 and PADDLE_X=13 at a step -> dy=-1, BALL_Y=56; with PADDLE_X=21 -> BALL_Y=57, and the ball later reaches 59 -> one-cycle BALL_LOST, BALL_VALID=0 for 60 frames, then SERVE.
REQ-025 LAUNCH during MOVING and RESET coincident with FRAME_START -> no effect and reset values respectively.
